// File: rtl/tile_pkg.sv
// Shared tile types and default geometry for the tile row generator.
package tile_pkg;

    typedef enum logic [1:0] {
        TILE_OUTLINE = 2'd0,
        TILE_SOLID   = 2'd1,
        TILE_BLANK   = 2'd2,
        TILE_DIAG    = 2'd3
    } tile_type_e;

    localparam int TILE_W_DEF = 60;
    localparam int TILE_H_DEF = 60;
    localparam int BORDER_DEF = 2;

endpackage

// File: rtl/tile_row_shape.sv
// Combinational row shaper: maps (tile type, row index) to one row of pixels.
// Rows at or beyond TILE_H come out all zero.
module tile_row_shape
    import tile_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEF,
    parameter int TILE_H = TILE_H_DEF,
    parameter int BORDER = BORDER_DEF
) (
    input  tile_type_e                  type_i,
    input  logic [$clog2(TILE_H+1)-1:0] yline_i,
    output logic [TILE_W-1:0]           row_o
);

    localparam int YW = $clog2(TILE_H+1);
    // Wide enough to hold y*TILE_W for any legal row without truncation.
    localparam int PW = $clog2(TILE_H) + $clog2(TILE_W) + 1;

    logic [PW-1:0] prod;
    logic [PW-1:0] col;
    logic          in_range;
    logic          edge_row;

    always_comb begin
        prod     = PW'(yline_i) * PW'(TILE_W);
        col      = prod / PW'(TILE_H);
        in_range = (yline_i < YW'(TILE_H));
        edge_row = (yline_i < YW'(BORDER)) || (yline_i >= YW'(TILE_H - BORDER));
        row_o    = '0;
        if (in_range) begin
            case (type_i)
                TILE_OUTLINE: begin
                    for (int i = 0; i < TILE_W; i++) begin
                        row_o[i] = edge_row || (i < BORDER) || (i >= TILE_W - BORDER);
                    end
                end
                TILE_SOLID: row_o = '1;
                TILE_BLANK: row_o = '0;
                TILE_DIAG: begin
                    // col counts from the left, so bit index is TILE_W-1-col.
                    for (int i = 0; i < TILE_W; i++) begin
                        row_o[i] = (col == PW'(TILE_W - 1 - i));
                    end
                end
                default: row_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/tile_row_gen.sv
// Tile row generator: one-stage valid/ready register around the row shaper.
// Optional TILE_ROW_GEN_MIRROR_EN adds in_mirror to bit-reverse produced rows.
module tile_row_gen
    import tile_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEF,
    parameter int TILE_H = TILE_H_DEF,
    parameter int BORDER = BORDER_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  in_type,
    input  logic [$clog2(TILE_H+1)-1:0] in_yline,
`ifdef TILE_ROW_GEN_MIRROR_EN
    input  logic                        in_mirror,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [TILE_W-1:0]           out_bitmap,
    output logic                        err_oob
);

    localparam int YW = $clog2(TILE_H+1);

    logic              valid_q, valid_d;
    logic [TILE_W-1:0] bitmap_q, bitmap_d;
    logic              err_q, err_d;
    logic [TILE_W-1:0] row_shaped;
    logic [TILE_W-1:0] row_final;
    logic              accept;

    tile_row_shape #(
        .TILE_W (TILE_W),
        .TILE_H (TILE_H),
        .BORDER (BORDER)
    ) u_shape (
        .type_i  (tile_type_e'(in_type)),
        .yline_i (in_yline),
        .row_o   (row_shaped)
    );

    always_comb begin
        row_final = row_shaped;
`ifdef TILE_ROW_GEN_MIRROR_EN
        if (in_mirror) begin
            for (int i = 0; i < TILE_W; i++) begin
                row_final[i] = row_shaped[TILE_W-1-i];
            end
        end
`endif
    end

    // Ready is forced low during reset so nothing is taken before the flush.
    assign in_ready = !rst && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d  = valid_q;
        bitmap_d = bitmap_q;
        err_d    = err_q;
        if (accept) begin
            valid_d  = 1'b1;
            bitmap_d = row_final;
            if (in_yline >= YW'(TILE_H)) begin
                err_d = 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bitmap_q <= '0;
            err_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            bitmap_q <= bitmap_d;
            err_q    <= err_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_bitmap = bitmap_q;
    assign err_oob    = err_q;

endmodule
